// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: EX-stage request/response bundle between the decode controls and the multiply sequencer.
interface mult_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             rd_req;
  logic             hi_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  modport master (output start, rd_req, hi_sel, a, b,
                  input  rd_data, hi, lo, busy, stall, done);
  modport slave  (input  start, rd_req, hi_sel, a, b,
                  output rd_data, hi, lo, busy, stall, done);
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-2 shift-add multiplier owning HI/LO, WIDTH+1 cycles per mult.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude with a final negate).
module mult_sequencer #(parameter int WIDTH = 32) (
  input logic              clk,
  input logic              rst_n,
  mult_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_acc, w_shift, w_prod;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo, w_a, w_b;
  logic [WIDTH:0]     w_sum;
  logic [CW-1:0]      r_cnt;
  logic               r_done, w_accept;
`ifdef MULT_SIGNED_EN
  logic               r_neg;
  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    w_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    w_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;
    w_prod = r_neg ? -r_acc : r_acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_neg <= 1'b0;
    else if (w_accept) r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
  always_comb begin
    w_a    = bus.a;
    w_b    = bus.b;
    w_prod = r_acc;
  end
`endif
  always_comb begin
    w_accept = (r_state == IDLE) & bus.start;
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_shift  = {w_sum, r_acc[WIDTH-1:1]};
    w_next   = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
               (r_state == RUN)  ? ((r_cnt == CW'(1)) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_state == DONE;
      if (w_accept) begin
        r_mcand <= w_a;
        r_acc   <= {{WIDTH{1'b0}}, w_b};
        r_cnt   <= CW'(WIDTH);
      end else if (r_state == RUN) begin
        r_acc <= w_shift;
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == DONE) {r_hi, r_lo} <= w_prod;
    end
  assign bus.busy    = r_state != IDLE;
  assign bus.stall   = bus.busy & (bus.start | bus.rd_req);
  assign bus.rd_data = bus.hi_sel ? r_hi : r_lo;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: table, random and hand-written sequences against an arithmetic product model.
module tb_mult_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  mult_sequencer_if #(.WIDTH(W)) bus ();
  mult_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_u;
    logic [2*W-1:0] exp_s;
  } vec_t;
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
    logic [2*W-1:0] sx = {{W{x[W-1]}}, x};
    logic [2*W-1:0] sy = {{W{y[W-1]}}, y};
    return sx * sy;
`else
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
  endfunction
  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic mult(input logic [W-1:0] x, input logic [W-1:0] y, output int n);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    vec_t tbl[8];
    int n, nst;
    logic [W-1:0] x, y;
    logic [2*W-1:0] e;
    tbl[0] = '{32'd7, 32'd6, 64'h0000_0000_0000_002A, 64'h0000_0000_0000_002A};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001};
    tbl[2] = '{32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    tbl[4] = '{32'h8000_0000, 32'd1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
    tbl[5] = '{32'd0, 32'hDEAD_BEEF, 64'd0, 64'd0};
    tbl[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
    tbl[7] = '{32'd3, 32'd5, 64'd15, 64'd15};
    bus.start = 1'b0;
    bus.rd_req = 1'b0;
    bus.hi_sel = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_stall_done", {bus.stall, bus.done}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mult(32'd7, 32'd6, n);
    chk("first_latency", 64'(n), 64'd33);
    chk("first_done", 64'(bus.done), 64'd1);
    chk("first_hilo", {bus.hi, bus.lo}, 64'h2A);
    @(negedge clk);
    chk("first_done_pulse", 64'(bus.done), 64'd0);
    for (int i = 0; i < 8; i++) begin
`ifdef MULT_SIGNED_EN
      e = tbl[i].exp_s;
`else
      e = tbl[i].exp_u;
`endif
      mult(tbl[i].a, tbl[i].b, n);
      chk($sformatf("tbl%0d_hilo", i), {bus.hi, bus.lo}, e);
      chk($sformatf("tbl%0d_model", i), model(tbl[i].a, tbl[i].b), e);
      chk($sformatf("tbl%0d_lat", i), 64'(n), 64'd33);
    end
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = $urandom;
      mult(x, y, n);
      chk($sformatf("rand%0d_hilo", i), {bus.hi, bus.lo}, model(x, y));
      bus.hi_sel = 1'($urandom_range(1));
      #1 chk($sformatf("rand%0d_rd", i), 64'(bus.rd_data), 64'(bus.hi_sel ? model(x, y) >> W : model(x, y) & 64'hFFFF_FFFF));
      @(negedge clk);
    end
    bus.hi_sel = 1'b0;
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.rd_req = 1'b1;
    nst = 0;
    n = 0;
    #1;
    while (bus.busy && n < 100) begin
      if (!bus.stall) nst++;
      n++;
      @(negedge clk);
      #1;
    end
    chk("rdbusy_stall_held", 64'(nst), 64'd0);
    chk("rdbusy_stall_release", 64'(bus.stall), 64'd0);
    chk("rdbusy_rd_data", 64'(bus.rd_data), 64'd15);
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    #1 chk("idle_start_rd_old", {bus.stall, bus.rd_data}, 64'd15);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd_req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("idle_start_rd_result", {bus.hi, bus.lo}, 64'd81);
    bus.a = 32'hFFFF;
    bus.b = 32'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mult(32'd2, 32'd2, n);
    chk("postrst_lo", 64'(bus.lo), 64'd4);
    chk("postrst_lat", 64'(n), 64'd33);
    bus.a = 32'd7;
    bus.b = 32'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(negedge clk);
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.start = 1'b1;
    #1 nst = int'(bus.stall);
    @(negedge clk);
    #1 nst += int'(bus.stall);
    chk("b2b_first", {bus.done, bus.lo}, {31'd0, 1'b1, 32'd42});
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_stall_count", 64'(nst), 64'd1);
    n = 1;
    while (!bus.done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_spacing", 64'(n), 64'd34);
    chk("b2b_second", {bus.hi, bus.lo}, 64'd15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
